// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with optional zero register, write-to-read bypass and busy scoreboard
// Ports: clk/rst (async active-high); we/waddr/wdata write port; raddr/rdata/rbusy packed read ports;
//        bset/bset_addr mark a register busy; busy_vec exposes the whole scoreboard.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DW-1:0]       wdata,
  input  logic [NREAD*AW-1:0] raddr,
  output logic [NREAD*DW-1:0] rdata,
  output logic [NREAD-1:0]    rbusy,
  input  logic                bset,
  input  logic [AW-1:0]       bset_addr,
  output logic [2**AW-1:0]    busy_vec
);
  localparam int N = 2**AW;
  logic [DW-1:0] r_mem [N];
  logic [N-1:0]  r_busy;
  logic          w_wr, w_bs, w_byp;
  assign w_wr  = we && !(ZERO_REG != 0 && waddr == '0);
  assign w_bs  = bset && !(ZERO_REG != 0 && bset_addr == '0);
  // bypass is suppressed during reset so reads stay zero while rst is held
  assign w_byp = BYPASS != 0 && w_wr && !rst;
  assign busy_vec = r_busy;
  // clear first, then set: a new producer supersedes the retiring writer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr) r_mem[waddr] <= wdata;
      if (w_wr) r_busy[waddr] <= 1'b0;
      if (w_bs) r_busy[bset_addr] <= 1'b1;
    end
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = raddr[g*AW +: AW];
    assign rdata[g*DW +: DW] = (ZERO_REG != 0 && w_ra == '0) ? {DW{1'b0}} :
                               (w_byp && waddr == w_ra) ? wdata : r_mem[w_ra];
    assign rbusy[g] = r_busy[w_ra];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of three regfile_sb configurations against an array model
module tb_regfile_sb;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic we = 0, bset = 0;
  logic [5:0] waddr = 0, baddr = 0;
  logic [63:0] wdata = 0;
  logic [5:0] ra [4] = '{0, 0, 0, 0};
  logic [63:0] a_rd, b_rd;
  logic [255:0] c_rd;
  logic [1:0] a_rb, b_rb;
  logic [3:0] c_rb;
  logic [31:0] a_bv, b_bv;
  logic [63:0] c_bv;
  int pass_cnt = 0, total = 0;
  logic [63:0] m [3][64];
  logic bz [3][64];
  int zr [3] = '{1, 0, 1};
  int bp [3] = '{1, 0, 1};
  int aw [3] = '{5, 5, 6};
  int nr [3] = '{2, 2, 4};
  logic [63:0] dm [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, {64{1'b1}}};
  regfile_sb u_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr[4:0]), .wdata(wdata[31:0]),
    .raddr({ra[1][4:0], ra[0][4:0]}), .rdata(a_rd), .rbusy(a_rb),
    .bset(bset), .bset_addr(baddr[4:0]), .busy_vec(a_bv));
  regfile_sb #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr[4:0]), .wdata(wdata[31:0]),
    .raddr({ra[1][4:0], ra[0][4:0]}), .rdata(b_rd), .rbusy(b_rb),
    .bset(bset), .bset_addr(baddr[4:0]), .busy_vec(b_bv));
  regfile_sb #(.DW(64), .AW(6), .NREAD(4)) u_c (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr({ra[3], ra[2], ra[1], ra[0]}), .rdata(c_rd), .rbusy(c_rb),
    .bset(bset), .bset_addr(baddr), .busy_vec(c_bv));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [5:0] amask(int k);
    return aw[k] == 6 ? 6'h3F : 6'h1F;
  endfunction
  function automatic logic [63:0] exp_rd(int k, int p);
    logic [5:0] a, w;
    a = ra[p] & amask(k);
    w = waddr & amask(k);
    if (zr[k] != 0 && a == 0) return 0;
    if (bp[k] != 0 && we && !rst && w == a) return wdata & dm[k];
    return m[k][a];
  endfunction
  function automatic logic [63:0] obs_rd(int k, int p);
    return k == 0 ? {32'b0, a_rd[p*32 +: 32]} : k == 1 ? {32'b0, b_rd[p*32 +: 32]} : c_rd[p*64 +: 64];
  endfunction
  function automatic logic obs_rb(int k, int p);
    return k == 0 ? a_rb[p] : k == 1 ? b_rb[p] : c_rb[p];
  endfunction
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [63:0] ev, ov;
      for (int p = 0; p < nr[k]; p++) begin
        logic [5:0] a;
        a = ra[p] & amask(k);
        chk($sformatf("rdata%0d_p%0d", k, p), obs_rd(k, p), exp_rd(k, p));
        chk($sformatf("rbusy%0d_p%0d", k, p), 64'(obs_rb(k, p)), (zr[k] != 0 && a == 0) ? 64'd0 : 64'(bz[k][a]));
      end
      ev = 0;
      for (int r = 0; r < (1 << aw[k]); r++) ev[r] = bz[k][r];
      ov = k == 0 ? {32'b0, a_bv} : k == 1 ? {32'b0, b_bv} : c_bv;
      chk($sformatf("busy_vec%0d", k), ov, ev);
    end
  endtask
  task automatic model_rst();
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 64; r++) begin
        m[k][r] = 0;
        bz[k][r] = 0;
      end
  endtask
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic [5:0] w, b;
      w = waddr & amask(k);
      b = baddr & amask(k);
      if (we && !(zr[k] != 0 && w == 0)) m[k][w] = wdata & dm[k];
      if (we) bz[k][w] = 0;
      if (bset && !(zr[k] != 0 && b == 0)) bz[k][b] = 1;
    end
  endtask
  task automatic drive(input logic w, input logic [5:0] wa, input logic [63:0] wd, input logic bs, input logic [5:0] ba);
    we = w;
    waddr = wa;
    wdata = wd;
    bset = bs;
    baddr = ba;
  endtask
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  initial begin
    #1000000 $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    model_rst();
    #12 check_all();
    @(posedge clk);
    #1 rst = 0;
    drive(1, 19, 123456, 0, 0);
    step();
    drive(1, 23, 654321, 0, 0);
    step();
    we = 0;
    ra[0] = 23;
    ra[1] = 19;
    #1 chk("t1_rd0", 64'(a_rd[31:0]), 654321);
    chk("t1_rd1", 64'(a_rd[63:32]), 123456);
    chk("t1_rbusy", 64'(a_rb), 0);
    step();
    drive(1, 19, 233, 0, 0);
    ra[0] = 19;
    #1 chk("t2_byp", 64'(a_rd[31:0]), 233);
    chk("t2_nobyp", 64'(b_rd[31:0]), 123456);
    step();
    we = 0;
    #1 chk("t2_a_after", 64'(a_rd[31:0]), 233);
    chk("t2_b_after", 64'(b_rd[31:0]), 233);
    drive(1, 0, 64'hDEADBEEF, 1, 0);
    ra[0] = 0;
    step();
    drive(0, 0, 0, 0, 0);
    #1 chk("t3_a_r0", 64'(a_rd[31:0]), 0);
    chk("t3_a_bv0", 64'(a_bv[0]), 0);
    chk("t3_a_rb", 64'(a_rb[0]), 0);
    chk("t3_b_r0", 64'(b_rd[31:0]), 64'hDEADBEEF);
    chk("t3_b_bv0", 64'(b_bv[0]), 1);
    chk("t3_b_rb", 64'(b_rb[0]), 1);
    step();
    drive(0, 0, 0, 1, 5);
    ra[0] = 5;
    step();
    bset = 0;
    #1 chk("t4_bv5", 64'(a_bv[5]), 1);
    chk("t4_rb", 64'(a_rb[0]), 1);
    drive(1, 5, 77, 0, 0);
    #1 chk("t4_rb_wr", 64'(a_rb[0]), 1);
    chk("t4_rd_byp", 64'(a_rd[31:0]), 77);
    step();
    we = 0;
    #1 chk("t4_bv5_clr", 64'(a_bv[5]), 0);
    drive(1, 7, 9, 1, 7);
    ra[0] = 7;
    step();
    drive(0, 0, 0, 0, 0);
    #1 chk("t5_rd7", 64'(a_rd[31:0]), 9);
    chk("t5_bv7", 64'(a_bv[7]), 1);
    drive(1, 9, 1, 1, 8);
    step();
    drive(0, 0, 0, 1, 5);
    #1 chk("t5_bv8", 64'(a_bv[8]), 1);
    chk("t5_bv9", 64'(a_bv[9]), 0);
    step();
    bset = 0;
    ra[0] = 19;
    #1 chk("t6_pre", 64'(a_rd[31:0]), 233);
    #1 rst = 1;
    model_rst();
    #1 chk("t6_rd", 64'(a_rd[31:0]), 0);
    chk("t6_bv", 64'(a_bv), 0);
    chk("t6_cbv", c_bv, 0);
    check_all();
    @(posedge clk);
    #1 rst = 0;
    drive(1, 63, 64'h0123456789ABCDEF, 0, 0);
    step();
    we = 0;
    ra[0] = 63;
    ra[1] = 1;
    ra[2] = 63;
    ra[3] = 0;
    #1 chk("t6_c_p0", c_rd[63:0], 64'h0123456789ABCDEF);
    chk("t6_c_p1", c_rd[127:64], 0);
    chk("t6_c_p2", c_rd[191:128], 64'h0123456789ABCDEF);
    chk("t6_c_p3", c_rd[255:192], 0);
    step();
    for (int i = 0; i < 400; i++) begin
      logic sm;
      sm = 1'($urandom);
      drive(1'($urandom), 6'(sm ? $urandom_range(0, 7) : $urandom_range(0, 63)), {$urandom, $urandom},
            1'($urandom), 6'(sm ? $urandom_range(0, 7) : $urandom_range(0, 63)));
      for (int p = 0; p < 4; p++) ra[p] = 6'(sm ? $urandom_range(0, 7) : $urandom_range(0, 63));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1;
        model_rst();
        #1 check_all();
        @(posedge clk);
        #1 rst = 0;
      end else step();
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU register file: configurable data width, depth and number of read ports.
- Adds an optional hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- Sits between decode (read addresses, busy set) and writeback (write port).

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth = 2**AW
NREAD, 2, number of read ports (>=1)
ZERO_REG, 1, 1: register 0 reads 0, its writes and busy sets are ignored; 0: register 0 is ordinary
BYPASS, 1, 1: a read of the address written this cycle returns wdata combinationally; 0: returns the stored value

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
we  in  1  write enable
waddr  in  AW  write address
wdata  in  DW  write data
raddr  in  NREAD*AW  packed read addresses; port i is bits [i*AW +: AW]
rdata  out  NREAD*DW  packed read data; port i is bits [i*DW +: DW]
rbusy  out  NREAD  busy flag of the register addressed by read port i
bset  in  1  mark register bset_addr busy (producer issued)
bset_addr  in  AW  register to mark busy
busy_vec  out  2**AW  full scoreboard, bit r = register r busy

Behaviour:
- Reset: asynchronous and active-high; it acts immediately, independent of clk.
  - While rst is high: all 2**AW registers = 0, all busy bits = 0, so rdata = 0, rbusy = 0 and busy_vec = 0.
  - The first write is accepted on the first rising edge after rst deasserts.
  - Asserting rst mid-sequence discards all contents and pending busy bits.
- Write:
  - On posedge clk with we=1, reg[waddr] <= wdata.
  - With ZERO_REG=1 and waddr=0, the write is dropped.
  - Write latency is 1 cycle to storage.
- Read:
  - Combinational, zero latency; each port is independent, and all ports may address the same register.
  - rdata_i = 0 if ZERO_REG and raddr_i=0.
  - Otherwise, if BYPASS and we and waddr==raddr_i (and waddr is not a dropped reg-0 write), rdata_i = wdata.
  - Otherwise rdata_i = reg[raddr_i].
- Scoreboard:
  - On posedge with bset=1, busy[bset_addr] <= 1. Ignored for address 0 when ZERO_REG.
  - On posedge with we=1, busy[waddr] <= 0.
  - Same cycle, same address: bset wins and the register ends busy (new producer supersedes the retiring one). The data is still written.
  - Same cycle, different addresses: both take effect.
  - Writing a register that is not busy is legal; its busy bit stays 0.
- rbusy_i:
  - Equals busy[raddr_i] from the registered state. It is not bypassed: a write in the current cycle does not clear rbusy until the next cycle.
  - Forced to 0 for register 0 when ZERO_REG.
- busy_vec: directly the registered busy bits; bit 0 is constant 0 when ZERO_REG.
- No X propagation: raddr is always in range by construction (2**AW entries).

Test Plan:
1. Reset, then write 123456 to r19 and 654321 to r23 on consecutive cycles, we=0, raddr={23,19} -> rdata port0=654321, port1=123456, rbusy=0.
2. BYPASS=1: we=1, waddr=19, wdata=233, raddr0=19 in the same cycle -> rdata0=233 before the edge, stored value 233 after. Rerun with BYPASS=0 -> rdata0=123456 before the edge, 233 after.
3. ZERO_REG=1: write 0xDEADBEEF to r0, bset on r0 -> rdata for r0=0, busy_vec[0]=0, rbusy=0. ZERO_REG=0: same stimulus -> r0 reads 0xDEADBEEF, and after the bset edge busy_vec[0]=1 and rbusy=1.
4. Scoreboard: bset r5 -> busy_vec[5]=1 and rbusy=1 for raddr=5 next cycle. Write r5=77 -> during the write cycle rbusy still 1 and rdata=77 (bypass); next cycle busy_vec[5]=0.
5. Simultaneous bset r7 and write r7=9 -> after the edge reg7=9 and busy_vec[7]=1. Simultaneous bset r8 and write r9 -> busy_vec[8]=1, busy_vec[9]=0.
6. Asynchronous reset mid-run, rst asserted between edges with r19=233 and r5 busy -> rdata=0 and busy_vec=0 immediately, with no clock edge. Rerun with NREAD=4, DW=64, AW=6: four ports reading r63, r1, r63, r0 after a write of 0x0123456789ABCDEF to r63 -> that value on ports 0 and 2, 0 on ports 1 and 3.
